step_control_multi: RTL and testbench

- Parametrised successor to the single-instruction stepping gate; sits between the debug switches/button and the fetch stage of the pipelined processor.
- Supports three modes:
  - free run;
  - N-instruction stepping per button press, with automatic pipeline drain;
  - PC breakpoint halt with skip-once resume.
- Tracks in-flight instructions itself, so no external "completed" signal is needed.

---
 rtl/step_control_multi_pkg.sv | 10 +
 rtl/step_control_multi_debounce.sv | 74 +++++++
 rtl/step_control_multi.sv | 154 +++++++++++++++
 tb/tb_step_control_multi.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_control_multi_pkg.sv
// Shared types and sizing helpers for the multi-instruction step controller.
package step_ctrl_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} step_state_t;

    function automatic int inflight_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/step_control_multi_debounce.sv
// Synchronises and debounces the raw step button into a single-cycle rise pulse.
module button_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   level;
    logic                   level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign level = sync_out;
        end else begin : g_filter
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

            logic          cand;
            logic [CW-1:0] cnt;
            logic [CW-1:0] cnt_next;

            // cnt counts consecutive equal samples, including the current one
            always_comb begin
                cnt_next = cnt;
                if (sync_out != cand) begin
                    cnt_next = CW'(1);
                end else if (cnt != CMAX) begin
                    cnt_next = cnt + CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cand  <= 1'b0;
                    cnt   <= '0;
                    level <= 1'b0;
                end else begin
                    cand <= sync_out;
                    cnt  <= cnt_next;
                    if (cnt_next == CMAX) begin
                        level <= sync_out;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/step_control_multi.sv
// Fetch gate for the debug front panel: free run, N-instruction stepping with drain,
// and PC breakpoints that let the breakpoint instruction through once on resume.
module step_control_multi
    import step_ctrl_pkg::*;
#(
    parameter int PC_W            = 32,
    parameter int CNT_W           = 8,
    parameter int PIPE_DEPTH      = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     step_button,
    input  logic                                     step_enable,
    input  logic [CNT_W-1:0]                         step_count,
    input  logic                                     bp_enable,
    input  logic [PC_W-1:0]                          bp_addr,
    input  logic [PC_W-1:0]                          fetch_pc,
    input  logic                                     fetch_fire,
    input  logic                                     instr_retire,
    output logic                                     fetch_enable,
    output logic                                     halted,
    output logic                                     bp_hit,
    output logic [inflight_width(PIPE_DEPTH)-1:0]    inflight
);

    localparam int IW = inflight_width(PIPE_DEPTH);
    localparam logic [IW-1:0] FULL = IW'(PIPE_DEPTH);

    step_state_t      state;
    logic             en_q;
    logic             bp_skip;
    logic             bp_pending;
    logic [CNT_W-1:0] remaining;
    logic [PC_W-1:0]  bp_addr_q;
    logic             step_pulse;
    logic             qual_fire;
    logic             bp_match;
    logic [IW-1:0]    inflight_next;

    button_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .button(step_button),
        .pulse (step_pulse)
    );

    // The breakpoint term is the only combinational path, so the match cycle never fetches
    assign bp_match     = bp_enable & (fetch_pc == bp_addr) & ~bp_skip;
    assign fetch_enable = en_q & ~((state == RUN) & bp_match);
    assign qual_fire    = fetch_fire & fetch_enable;

    always_comb begin
        inflight_next = inflight;
        if (qual_fire && !instr_retire && inflight != FULL) begin
            inflight_next = inflight + IW'(1);
        end else if (!qual_fire && instr_retire && inflight != '0) begin
            inflight_next = inflight - IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            inflight <= inflight_next;
        end
    end

    // Skip flag lets the breakpoint instruction through exactly once after a halt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_skip   <= 1'b0;
            bp_addr_q <= '0;
        end else begin
            bp_addr_q <= bp_addr;
            if (state == RUN && bp_match) begin
                bp_skip <= 1'b1;
            end else if (qual_fire || bp_addr != bp_addr_q) begin
                bp_skip <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            en_q       <= 1'b1;
            halted     <= 1'b0;
            bp_hit     <= 1'b0;
            bp_pending <= 1'b0;
            remaining  <= '0;
        end else begin
            bp_hit <= 1'b0;
            unique case (state)
                RUN: begin
                    if (bp_match) begin
                        state      <= DRAIN;
                        en_q       <= 1'b0;
                        bp_hit     <= 1'b1;
                        bp_pending <= 1'b1;
                    end else if (step_enable) begin
                        state <= DRAIN;
                        en_q  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (inflight_next == '0) begin
                        state      <= HALTED;
                        halted     <= 1'b1;
                        bp_pending <= 1'b0;
                    end else if (!step_enable && !bp_pending) begin
                        state <= RUN;
                        en_q  <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!step_enable) begin
                        state  <= RUN;
                        en_q   <= 1'b1;
                        halted <= 1'b0;
                    end else if (step_pulse) begin
                        state     <= STEP;
                        en_q      <= 1'b1;
                        halted    <= 1'b0;
                        remaining <= (step_count == '0) ? CNT_W'(1) : step_count;
                    end
                end
                STEP: begin
                    if (!step_enable) begin
                        state     <= RUN;
                        en_q      <= 1'b1;
                        remaining <= '0;
                    end else if (qual_fire) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DRAIN;
                            en_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= RUN;
                    en_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_control_multi.sv
// Directed and random checks of step_control_multi against a cycle-level behavioural model.
module tb_step_control_multi;

    localparam int S     = 2;
    localparam int D     = 16;
    localparam int DEPTH = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        step_button, step_enable, bp_enable, fetch_fire, instr_retire;
    logic [7:0]  step_count;
    logic [31:0] bp_addr, fetch_pc;
    logic        fetch_enable, halted, bp_hit;
    logic [2:0]  inflight;

    int tests_run = 0;
    int tests_failed = 0;
    int accepted;

    int m_inflight, m_left;
    bit m_en, m_halted, m_bphit, m_skip, m_bp_wait, m_stopping, m_stepping;
    bit m_pulse, m_level, m_level_prev;
    logic [31:0] m_prev_addr;
    bit raw_hist[$];

    int bounce[10] = '{1, 0, 1, 0, 1, 0, 1, 1, 1, 1};

    step_control_multi dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .step_button (step_button),
        .step_enable (step_enable),
        .step_count  (step_count),
        .bp_enable   (bp_enable),
        .bp_addr     (bp_addr),
        .fetch_pc    (fetch_pc),
        .fetch_fire  (fetch_fire),
        .instr_retire(instr_retire),
        .fetch_enable(fetch_enable),
        .halted      (halted),
        .bp_hit      (bp_hit),
        .inflight    (inflight)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_running();
        return !(m_stopping || m_halted || m_stepping);
    endfunction

    function automatic bit model_bp_match();
        return bp_enable && (fetch_pc == bp_addr) && !m_skip;
    endfunction

    function automatic bit model_fetch_enable();
        return m_en && !(model_running() && model_bp_match());
    endfunction

    task automatic model_reset();
        m_inflight = 0; m_left = 0;
        m_en = 1; m_halted = 0; m_bphit = 0; m_skip = 0; m_bp_wait = 0;
        m_stopping = 0; m_stepping = 0;
        m_pulse = 0; m_level = 0; m_level_prev = 0;
        m_prev_addr = '0;
        raw_hist.delete();
        for (int i = 0; i < S + D; i++) raw_hist.push_back(1'b0);
    endtask

    // One clock of the model: button accepted after D equal samples seen S cycles late
    task automatic model_step();
        bit fe, fire, running, bpm, pulse_seen, all1, all0, set_skip;
        fe = model_fetch_enable();
        fire = fetch_fire && fe;
        running = model_running();
        bpm = model_bp_match();
        pulse_seen = m_pulse;
        set_skip = 0;

        if (fire && !instr_retire && m_inflight < DEPTH) m_inflight++;
        else if (!fire && instr_retire && m_inflight > 0) m_inflight--;

        m_pulse = m_level && !m_level_prev;
        m_level_prev = m_level;
        raw_hist.push_back(step_button);
        void'(raw_hist.pop_front());
        all1 = 1; all0 = 1;
        for (int i = 0; i < D; i++) begin
            if (raw_hist[i]) all0 = 0; else all1 = 0;
        end
        if (all1) m_level = 1; else if (all0) m_level = 0;

        m_bphit = 0;
        if (running) begin
            if (bpm) begin
                m_stopping = 1; m_bp_wait = 1; m_bphit = 1; m_en = 0; set_skip = 1;
            end else if (step_enable) begin
                m_stopping = 1; m_en = 0;
            end
        end else if (m_stopping) begin
            if (m_inflight == 0) begin
                m_stopping = 0; m_halted = 1; m_bp_wait = 0;
            end else if (!step_enable && !m_bp_wait) begin
                m_stopping = 0; m_en = 1;
            end
        end else if (m_halted) begin
            if (!step_enable) begin
                m_halted = 0; m_en = 1;
            end else if (pulse_seen) begin
                m_halted = 0; m_stepping = 1; m_en = 1;
                m_left = (step_count == 0) ? 1 : int'(step_count);
            end
        end else begin
            if (!step_enable) begin
                m_stepping = 0; m_en = 1;
            end else if (fire) begin
                m_left--;
                if (m_left == 0) begin
                    m_stepping = 0; m_stopping = 1; m_en = 0;
                end
            end
        end

        if (set_skip) m_skip = 1;
        else if (fire || bp_addr != m_prev_addr) m_skip = 0;
        m_prev_addr = bp_addr;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic check_all();
        checkOutput("fetch_enable", fetch_enable, model_fetch_enable());
        checkOutput("halted", halted, m_halted);
        checkOutput("bp_hit", bp_hit, m_bphit);
        checkOutput("inflight", inflight, m_inflight);
    endtask

    task automatic applyStimulus(input bit fire, input bit retire);
        fetch_fire = fire;
        instr_retire = retire;
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; step_button = 0; step_enable = 0; step_count = 0;
        bp_enable = 0; bp_addr = 32'h40; fetch_pc = '0; fetch_fire = 0; instr_retire = 0;
        @(negedge clk); @(negedge clk);
        check_all();
        checkOutput("rst_fetch_enable", fetch_enable, 1);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_inflight", inflight, 0);
        rst_n = 1;

        repeat (3) applyStimulus(1, 0);
        applyStimulus(0, 1);
        checkOutput("inflight_3fire_1retire", inflight, 2);

        applyStimulus(1, 0);
        checkOutput("inflight_three", inflight, 3);
        step_enable = 1;
        applyStimulus(0, 0);
        checkOutput("drain_entry_fe", fetch_enable, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1);
            checkOutput("drain_fe_hold", fetch_enable, 0);
        end
        checkOutput("drain_halted", halted, 1);
        checkOutput("drain_inflight", inflight, 0);

        // Clean press: pulse lands S+D+1 edges after the press, STEP one edge later
        step_count = 4;
        step_button = 1;
        for (int i = 0; i < 19; i++) applyStimulus(0, 0);
        checkOutput("press_wait_halted", halted, 1);
        checkOutput("press_wait_fe", fetch_enable, 0);
        applyStimulus(0, 0);
        checkOutput("step_start_fe", fetch_enable, 1);
        checkOutput("step_start_halted", halted, 0);
        step_button = 0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            fetch_fire = 1; #1;
            if (fetch_enable) accepted++;
            applyStimulus(1, 0);
        end
        checkOutput("step4_accepted", accepted, 4);
        checkOutput("step4_inflight", inflight, 4);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1);
        checkOutput("step4_halted", halted, 1);

        step_count = 0;
        repeat (10) applyStimulus(0, 0);
        for (int i = 0; i < 10; i++) begin
            step_button = bounce[i][0];
            applyStimulus(0, 0);
        end
        accepted = 0;
        for (int i = 0; i < 40; i++) begin
            fetch_fire = 1; #1;
            if (fetch_enable) accepted++;
            applyStimulus(1, 0);
        end
        checkOutput("count0_bounce_accepted", accepted, 1);
        step_button = 0;
        applyStimulus(0, 1);
        checkOutput("count0_halted", halted, 1);

        step_enable = 0;
        applyStimulus(0, 0);
        checkOutput("resume_run_fe", fetch_enable, 1);
        bp_enable = 1;
        for (int i = 0; i < 6; i++) begin
            fetch_pc = 32'h28 + 32'(4 * i);
            applyStimulus(1, 0);
        end
        checkOutput("inflight_saturate", inflight, 5);
        fetch_pc = 32'h40; fetch_fire = 1; #1;
        checkOutput("bp_same_cycle_fe", fetch_enable, 0);
        applyStimulus(1, 0);
        checkOutput("bp_hit_pulse", bp_hit, 1);
        checkOutput("bp_not_fetched", inflight, 5);
        step_enable = 1;
        applyStimulus(0, 1);
        checkOutput("bp_hit_once", bp_hit, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1);
        checkOutput("bp_halted", halted, 1);
        applyStimulus(0, 1);
        checkOutput("retire_at_zero", inflight, 0);
        step_enable = 0;
        applyStimulus(0, 0);
        checkOutput("bp_resume_halted", halted, 0);
        fetch_fire = 1; #1;
        checkOutput("bp_skip_fe", fetch_enable, 1);
        applyStimulus(1, 0);
        fetch_pc = 32'h44;
        applyStimulus(1, 0);
        fetch_pc = 32'h40; #1;
        checkOutput("bp_rearm_fe", fetch_enable, 0);
        applyStimulus(1, 0);
        checkOutput("bp_rearm_hit", bp_hit, 1);
        repeat (3) applyStimulus(0, 1);
        bp_enable = 0; fetch_pc = '0;
        applyStimulus(0, 0);

        // Abandon a step part-way through with an asynchronous reset
        step_enable = 1;
        repeat (3) applyStimulus(0, 0);
        step_count = 3;
        step_button = 1;
        for (int i = 0; i < 20; i++) applyStimulus(0, 0);
        checkOutput("midstep_fe", fetch_enable, 1);
        step_button = 0;
        applyStimulus(1, 0);
        checkOutput("midstep_inflight", inflight, 1);
        #2 rst_n = 0;
        #1;
        check_all();
        checkOutput("async_rst_fe", fetch_enable, 1);
        checkOutput("async_rst_halted", halted, 0);
        checkOutput("async_rst_inflight", inflight, 0);
        @(negedge clk);
        step_enable = 0;
        rst_n = 1;
        repeat (2) applyStimulus(0, 0);
        checkOutput("post_rst_fe", fetch_enable, 1);
        checkOutput("post_rst_halted", halted, 0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) step_enable = ~step_enable;
            if ($urandom_range(0, 59) == 0) bp_enable = ~bp_enable;
            if ($urandom_range(0, 79) == 0) bp_addr = 32'h40 + 32'(4 * $urandom_range(0, 2));
            if ($urandom_range(0, 29) == 0) step_button = ~step_button;
            fetch_pc = 32'h40 + 32'(4 * $urandom_range(0, 2));
            step_count = 8'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
